// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared defaults and helpers for the parameterised FIFO.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and entry count.
//   ptr_w(depth)                  : pointer width, index bits plus one wrap bit.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  // The extra MSB distinguishes full from empty when the index bits match,
  // so all DEPTH entries can be occupied.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
//   Simple dual-port storage: one synchronous write port, one synchronous
//   read port. Contents are never reset.
//   clk     : clock
//   wr_en   : write strobe, stores wr_data at wr_addr
//   wr_addr : write index
//   wr_data : write data
//   rd_en   : read strobe, loads rd_data from rd_addr
//   rd_addr : read index
//   rd_data : registered read data, holds when rd_en is low
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A same-address write and read return the old word, which is what the
  // FIFO needs when it is full and reads and writes in the same cycle.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/param_fifo.sv
// param_fifo
//   Synchronous FIFO with occupancy count, almost-full/almost-empty flags and
//   sticky overflow/underflow error flags.
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   wr_en        : write request
//   data_in      : write data
//   r_en         : read request
//   clr_err      : clears overflow/underflow (a same-cycle set wins)
//   out          : registered read data, one cycle after an accepted read
//   valid        : high for one cycle when out carries newly read data
//   full, empty  : occupancy flags, combinational from registered pointers
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : occupancy, 0..DEPTH
//   overflow     : sticky, write requested while rejected
//   underflow    : sticky, read requested while empty
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      r_en,
  input  logic                      clr_err,
  output logic [WIDTH-1:0]          out,
  output logic                      valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count_q;
  logic             wr_acc;
  logic             rd_acc;
  logic             vld_p1;
  logic             rd_seen;
  logic [WIDTH-1:0] rd_data_p1;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A write into a full FIFO is allowed when a read frees the head slot in
  // the same cycle. A write into an empty FIFO is never forwarded to a read.
  assign rd_acc = r_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  assign almost_full  = (count_q >= AF_L);
  assign almost_empty = (count_q <= AE_L);
  assign count        = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data_p1)
  );

  // ---- stage p1: read data and its valid leave the storage ----
  // The storage read register has no reset, so out is forced to zero until
  // the first read after reset has loaded a real word. rd_data_p1 only
  // changes on an accepted read, which gives the hold behaviour for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) begin
        rd_seen <= 1'b1;
      end
    end
  end

  assign valid = vld_p1;
  assign out   = rd_seen ? rd_data_p1 : '0;

endmodule

// File: tb/tb_param_fifo.sv
module tb_param_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AF    = DEPTH - 4;
  localparam int AE    = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic             r_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] out;
  logic             valid, full, empty, almost_full, almost_empty;
  logic             overflow, underflow;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  param_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .clr_err      (clr_err),
    .out          (out),
    .valid        (valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a queue of stored words plus the visible registers.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_out;
  logic             m_valid, m_ovf, m_udf;

  wire [CW+6:0] dut_st = {full, empty, almost_full, almost_empty,
                          overflow, underflow, valid, count};

  function automatic logic [CW+6:0] exp_st();
    int n;
    n = q.size();
    return {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_udf, m_valid, CW'(n)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // Applies one clock edge worth of FIFO rules to the model.
  task automatic model_edge(input logic w, input logic r, input logic [WIDTH-1:0] d,
                            input logic c);
    logic is_full, is_empty, rd_ok, wr_ok;
    is_full  = (q.size() == DEPTH);
    is_empty = (q.size() == 0);
    rd_ok    = r && !is_empty;
    wr_ok    = w && (!is_full || rd_ok);
    m_valid  = rd_ok;
    if (rd_ok) m_out = q.pop_front();
    if (wr_ok) q.push_back(d);
    if (w && !wr_ok) m_ovf = 1'b1;
    else if (c)      m_ovf = 1'b0;
    if (r && is_empty) m_udf = 1'b1;
    else if (c)        m_udf = 1'b0;
  endtask

  task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d,
                       input logic c);
    wr_en   = w;
    r_en    = r;
    data_in = d;
    clr_err = c;
    @(posedge clk);
    model_edge(w, r, d, c);
    #1;
    wr_en   = 1'b0;
    r_en    = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dut_st !== exp_st() || out !== m_out) begin
      miscompares++;
      $display("FAIL reset: status=%h out=%h, want status=%h out=%h",
               dut_st, out, exp_st(), m_out);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) cycle(1'b1, 1'b0, words[i], 1'b0);
      else       cycle(1'b0, 1'b1, '0, 1'b0);
      vectors++;
      if (dut_st !== exp_st() || out !== m_out) begin
        miscompares++;
        $display("FAIL basic step %0d: status=%h out=%h, want status=%h out=%h",
                 i, dut_st, out, exp_st(), m_out);
      end
    end
    vectors++;
    if (out !== 32'h33 || empty !== 1'b1 || count !== '0) begin
      miscompares++;
      $display("FAIL basic_end: out=%h empty=%b count=%0d, want out=33 empty=1 count=0",
               out, empty, count);
    end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < DEPTH + 1; i++) begin
      cycle(1'b1, 1'b0, $urandom, 1'b0);
      vectors++;
      if (dut_st !== exp_st() || out !== m_out) begin
        miscompares++;
        $display("FAIL fill %0d: status=%h out=%h, want status=%h out=%h",
                 i, dut_st, out, exp_st(), m_out);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0, 1'b0);
      vectors++;
      if (dut_st !== exp_st() || out !== m_out) begin
        miscompares++;
        $display("FAIL drain %0d: status=%h out=%h, want status=%h out=%h",
                 i, dut_st, out, exp_st(), m_out);
      end
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    vectors++;
    if (dut_st !== exp_st()) begin
      miscompares++;
      $display("FAIL clr_ovf: status=%h, want %h", dut_st, exp_st());
    end
  endtask

  task automatic test_full_simul();
    logic [WIDTH-1:0] last;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, $urandom, 1'b0);
    last = $urandom;
    cycle(1'b1, 1'b1, last, 1'b0);
    vectors++;
    if (dut_st !== exp_st() || out !== m_out || count !== CW'(DEPTH)) begin
      miscompares++;
      $display("FAIL full_rw: status=%h out=%h, want status=%h out=%h",
               dut_st, out, exp_st(), m_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0, 1'b0);
      vectors++;
      if (dut_st !== exp_st() || out !== m_out) begin
        miscompares++;
        $display("FAIL full_rw_drain %0d: status=%h out=%h, want status=%h out=%h",
                 i, dut_st, out, exp_st(), m_out);
      end
    end
    vectors++;
    if (out !== last) begin
      miscompares++;
      $display("FAIL full_rw_last: out=%h, want %h", out, last);
    end
  endtask

  task automatic test_empty_simul();
    cycle(1'b1, 1'b1, 32'hC0DE_0001, 1'b0);
    vectors++;
    if (dut_st !== exp_st() || valid !== 1'b0 || count !== CW'(1) || underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_rw: status=%h, want %h", dut_st, exp_st());
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    vectors++;
    if (dut_st !== exp_st() || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_udf: status=%h, want %h", dut_st, exp_st());
    end
    cycle(1'b0, 1'b1, '0, 1'b0);
    // Underflow set in the same cycle as clr_err: the set must win.
    cycle(1'b0, 1'b1, '0, 1'b1);
    vectors++;
    if (dut_st !== exp_st() || out !== m_out || underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL udf_set_wins: status=%h out=%h, want status=%h out=%h",
               dut_st, out, exp_st(), m_out);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_wrap_random();
    int n;
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, $urandom, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cycle(($urandom_range(3) != 0), ($urandom_range(3) != 0), $urandom, 1'b0);
      vectors++;
      if (dut_st !== exp_st() || out !== m_out) begin
        miscompares++;
        $display("FAIL wrap %0d: status=%h out=%h, want status=%h out=%h",
                 i, dut_st, out, exp_st(), m_out);
      end
    end
    // Sweep occupancy across both thresholds and back.
    n = q.size();
    for (int i = n; i < 30; i++) begin
      cycle(1'b1, 1'b0, $urandom, 1'b0);
      vectors++;
      if (dut_st !== exp_st()) begin
        miscompares++;
        $display("FAIL sweep_up %0d: status=%h, want %h", i, dut_st, exp_st());
      end
    end
    while (q.size() > 0) begin
      cycle(1'b0, 1'b1, '0, 1'b0);
      vectors++;
      if (dut_st !== exp_st() || out !== m_out) begin
        miscompares++;
        $display("FAIL sweep_down: status=%h out=%h, want status=%h out=%h",
                 dut_st, out, exp_st(), m_out);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, (i > 2), $urandom, 1'b0);
    wr_en   = 1'b1;
    r_en    = 1'b1;
    data_in = 32'hDEAD_BEEF;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (dut_st !== exp_st() || out !== m_out) begin
      miscompares++;
      $display("FAIL async_rst: status=%h out=%h, want status=%h out=%h",
               dut_st, out, exp_st(), m_out);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (dut_st !== exp_st() || out !== m_out) begin
      miscompares++;
      $display("FAIL async_rst_hold: status=%h out=%h, want status=%h out=%h",
               dut_st, out, exp_st(), m_out);
    end
    wr_en = 1'b0;
    r_en  = 1'b0;
    #2;
    rst = 1'b1;
    cycle(1'b1, 1'b0, 32'hA5, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0);
    vectors++;
    if (dut_st !== exp_st() || out !== 32'hA5 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL post_rst_a5: out=%h valid=%b status=%h, want out=a5 valid=1 status=%h",
               out, valid, dut_st, exp_st());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overflow();
    test_full_simul();
    test_empty_simul();
    test_wrap_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning entry count; legal values are powers of two from 4 to 256.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-4, meaning the count at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 4, meaning the count at or below which almost_empty asserts.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, the asynchronous active-low reset.
REQ-007 The block SHALL have port wr_en, input, 1 bit, the write request.
REQ-008 The block SHALL have port data_in, input, WIDTH bits, the write data.
REQ-009 The block SHALL have port r_en, input, 1 bit, the read request.
REQ-010 The block SHALL have port clr_err, input, 1 bit, which clears the sticky error flags.
REQ-011 The block SHALL have port out, output, WIDTH bits, the registered read data.
REQ-012 The block SHALL have port valid, output, 1 bit, which is high for one cycle when out carries newly read data.
REQ-013 The block SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit, as the status flags.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, the current occupancy from 0 to DEPTH.
REQ-015 The block SHALL have ports overflow and underflow, each an output of 1 bit, as sticky error flags.

Function
REQ-016 Write and read pointers SHALL each be $clog2(DEPTH)+1 bits wide, with the MSB used as the wrap bit, so that every one of the DEPTH entries is usable.
REQ-017 empty SHALL assert when the pointers are fully equal; full SHALL assert when the index bits are equal and the wrap bits differ; both flags SHALL be combinational from registered pointers.
REQ-018 A write SHALL be accepted when wr_en=1 and (full=0, or a read is accepted in the same cycle); an accepted write stores data_in at the write index and increments the write pointer modulo 2*DEPTH.
REQ-019 A read SHALL be accepted when r_en=1 and empty=0; a simultaneous write to an empty FIFO SHALL NOT bypass to the read.
REQ-020 An accepted read at edge N SHALL load out with the head entry and set valid=1 during cycle N+1; read latency is 1 cycle.
REQ-021 Without an accepted read, out SHALL hold its previous value and valid SHALL be 0.
REQ-022 count SHALL increment on an accepted write alone, decrement on an accepted read alone, and stay unchanged when both or neither are accepted.
REQ-023 almost_full SHALL equal (count >= AF_LEVEL), and almost_empty SHALL equal (count <= AE_LEVEL).
REQ-024 overflow SHALL set when wr_en=1 and the write is rejected, and underflow SHALL set when r_en=1 and empty=1.
REQ-025 clr_err SHALL clear overflow and underflow on the next edge; if a set condition occurs in the same cycle as clr_err, the set SHALL win.
REQ-026 A rejected operation SHALL leave the pointers, the storage and count unchanged.

Reset
REQ-027 While rst=0, the block SHALL asynchronously drive pointers=0, count=0, out=0, valid=0, overflow=0 and underflow=0; empty=1, almost_empty=1, full=0 and almost_full=0 follow from these values.
REQ-028 The storage array SHALL NOT be reset, and its contents SHALL be unobservable until written.
REQ-029 Reset asserted mid-operation SHALL discard all entries; the first read after release SHALL return the first post-reset write.

Structure
REQ-030 Package fifo_pkg SHALL hold the default WIDTH and DEPTH constants and a function computing the pointer width.
REQ-031 Storage SHALL be a sub-module fifo_mem (one synchronous write port and one synchronous read port, no reset); pointer, flag and error logic SHALL reside in param_fifo.

Verification
REQ-032 The bench SHALL cover this scenario: reset, write 0x11, 0x22 and 0x33, then read 3 -> out=0x11, 0x22 and 0x33 on consecutive cycles with valid=1; empty=1 and count=0 at the end.
REQ-033 The bench SHALL cover this scenario: with DEPTH=32, write 32 words -> full=1 and count=32; a 33rd write -> overflow=1 and the data is unchanged; reading 32 returns all words in order.
REQ-034 The bench SHALL cover this scenario: full FIFO with wr_en=1 and r_en=1 in one cycle -> both accepted, count stays 32, and the new word is read last.
REQ-035 The bench SHALL cover this scenario: empty FIFO with wr_en=1 and r_en=1 -> write only, valid=0, count=1, and underflow=1; clr_err then -> underflow=0.
REQ-036 The bench SHALL cover this scenario: 100 write/read cycles at count near 16 -> pointers wrap past 31 and then 63, FIFO order is preserved, almost_full and almost_empty toggle at 28 and 4.
REQ-037 The bench SHALL cover this scenario: rst=0 pulsed asynchronously mid-burst, between clock edges -> outputs take reset values immediately; after release a write then read of 0xA5 -> out=0xA5.
